// File: rtl/tl_a_client_arbiter.sv
// Two-client TileLink-UL arbiter: round-robin A with grant lock on stall, D routed by source[9].
// A/D datapaths are combinational; only grant and per-client credit state is registered.
module tl_a_client_arbiter #(
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic        clock,
   input  logic        reset,
   // client 0
   output logic        auto_in0_a_ready,
   input  logic        auto_in0_a_valid,
   input  logic [2:0]  auto_in0_a_bits_opcode,
   input  logic [2:0]  auto_in0_a_bits_param,
   input  logic [1:0]  auto_in0_a_bits_size,
   input  logic [8:0]  auto_in0_a_bits_source,
   input  logic [32:0] auto_in0_a_bits_address,
   input  logic [7:0]  auto_in0_a_bits_mask,
   input  logic [63:0] auto_in0_a_bits_data,
   input  logic        auto_in0_d_ready,
   output logic        auto_in0_d_valid,
   output logic [2:0]  auto_in0_d_bits_opcode,
   output logic [1:0]  auto_in0_d_bits_param,
   output logic [1:0]  auto_in0_d_bits_size,
   output logic [8:0]  auto_in0_d_bits_source,
   output logic        auto_in0_d_bits_sink,
   output logic        auto_in0_d_bits_denied,
   output logic [63:0] auto_in0_d_bits_data,
   output logic        auto_in0_d_bits_corrupt,
   // client 1
   output logic        auto_in1_a_ready,
   input  logic        auto_in1_a_valid,
   input  logic [2:0]  auto_in1_a_bits_opcode,
   input  logic [2:0]  auto_in1_a_bits_param,
   input  logic [1:0]  auto_in1_a_bits_size,
   input  logic [8:0]  auto_in1_a_bits_source,
   input  logic [32:0] auto_in1_a_bits_address,
   input  logic [7:0]  auto_in1_a_bits_mask,
   input  logic [63:0] auto_in1_a_bits_data,
   input  logic        auto_in1_d_ready,
   output logic        auto_in1_d_valid,
   output logic [2:0]  auto_in1_d_bits_opcode,
   output logic [1:0]  auto_in1_d_bits_param,
   output logic [1:0]  auto_in1_d_bits_size,
   output logic [8:0]  auto_in1_d_bits_source,
   output logic        auto_in1_d_bits_sink,
   output logic        auto_in1_d_bits_denied,
   output logic [63:0] auto_in1_d_bits_data,
   output logic        auto_in1_d_bits_corrupt,
   // shared buffered link
   input  logic        auto_out_a_ready,
   output logic        auto_out_a_valid,
   output logic [2:0]  auto_out_a_bits_opcode,
   output logic [2:0]  auto_out_a_bits_param,
   output logic [1:0]  auto_out_a_bits_size,
   output logic [9:0]  auto_out_a_bits_source,
   output logic [32:0] auto_out_a_bits_address,
   output logic [7:0]  auto_out_a_bits_mask,
   output logic [63:0] auto_out_a_bits_data,
   output logic        auto_out_d_ready,
   input  logic        auto_out_d_valid,
   input  logic [2:0]  auto_out_d_bits_opcode,
   input  logic [1:0]  auto_out_d_bits_param,
   input  logic [1:0]  auto_out_d_bits_size,
   input  logic [9:0]  auto_out_d_bits_source,
   input  logic        auto_out_d_bits_sink,
   input  logic        auto_out_d_bits_denied,
   input  logic [63:0] auto_out_d_bits_data,
   input  logic        auto_out_d_bits_corrupt,
   output logic        stray_d_err
);

   localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

   logic       last_q, last_d, lock_q, lock_d, lock_id_q, lock_id_d, err_q, err_d;
   logic [3:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
   logic       elig0, elig1, win, win_elig, a_fire, d_id, d_fire, d_hit_zero;

   // Eligibility uses registered counts, so a same-cycle D never unmasks a full client.
   assign elig0 = auto_in0_a_valid && (cnt0_q < MAX_CNT);
   assign elig1 = auto_in1_a_valid && (cnt1_q < MAX_CNT);

   always_comb begin
      win = 1'b0;
      if (lock_q)              win = lock_id_q;
      else if (elig0 && elig1) win = ~last_q;
      else if (elig1)          win = 1'b1;
   end

   assign win_elig         = win ? elig1 : elig0;
   assign auto_out_a_valid = reset & win_elig;
   assign auto_in0_a_ready = reset & auto_out_a_ready & ~win & elig0;
   assign auto_in1_a_ready = reset & auto_out_a_ready &  win & elig1;
   assign a_fire           = auto_out_a_valid & auto_out_a_ready;

   assign auto_out_a_bits_opcode  = win ? auto_in1_a_bits_opcode  : auto_in0_a_bits_opcode;
   assign auto_out_a_bits_param   = win ? auto_in1_a_bits_param   : auto_in0_a_bits_param;
   assign auto_out_a_bits_size    = win ? auto_in1_a_bits_size    : auto_in0_a_bits_size;
   assign auto_out_a_bits_source  = {win, (win ? auto_in1_a_bits_source : auto_in0_a_bits_source)};
   assign auto_out_a_bits_address = win ? auto_in1_a_bits_address : auto_in0_a_bits_address;
   assign auto_out_a_bits_mask    = win ? auto_in1_a_bits_mask    : auto_in0_a_bits_mask;
   assign auto_out_a_bits_data    = win ? auto_in1_a_bits_data    : auto_in0_a_bits_data;

   assign d_id             = auto_out_d_bits_source[9];
   assign auto_in0_d_valid = reset & auto_out_d_valid & ~d_id;
   assign auto_in1_d_valid = reset & auto_out_d_valid &  d_id;
   assign auto_out_d_ready = reset & (d_id ? auto_in1_d_ready : auto_in0_d_ready);
   assign d_fire           = auto_out_d_valid & auto_out_d_ready;
   assign d_hit_zero       = d_fire && ((d_id ? cnt1_q : cnt0_q) == 4'd0);

   assign auto_in0_d_bits_opcode  = auto_out_d_bits_opcode;
   assign auto_in0_d_bits_param   = auto_out_d_bits_param;
   assign auto_in0_d_bits_size    = auto_out_d_bits_size;
   assign auto_in0_d_bits_source  = auto_out_d_bits_source[8:0];
   assign auto_in0_d_bits_sink    = auto_out_d_bits_sink;
   assign auto_in0_d_bits_denied  = auto_out_d_bits_denied;
   assign auto_in0_d_bits_data    = auto_out_d_bits_data;
   assign auto_in0_d_bits_corrupt = auto_out_d_bits_corrupt;
   assign auto_in1_d_bits_opcode  = auto_out_d_bits_opcode;
   assign auto_in1_d_bits_param   = auto_out_d_bits_param;
   assign auto_in1_d_bits_size    = auto_out_d_bits_size;
   assign auto_in1_d_bits_source  = auto_out_d_bits_source[8:0];
   assign auto_in1_d_bits_sink    = auto_out_d_bits_sink;
   assign auto_in1_d_bits_denied  = auto_out_d_bits_denied;
   assign auto_in1_d_bits_data    = auto_out_d_bits_data;
   assign auto_in1_d_bits_corrupt = auto_out_d_bits_corrupt;

   assign stray_d_err = reset & err_q;

   // Saturating credit update; simultaneous A and D for one client cancel out.
   function automatic logic [3:0] next_cnt(input logic [3:0] c, input logic inc, input logic dec);
      logic [3:0] n;
      n = c;
      if (inc && !dec && (c < MAX_CNT)) n = c + 4'd1;
      else if (dec && !inc && (c != 4'd0)) n = c - 4'd1;
      return n;
   endfunction

   always_comb begin
      last_d    = last_q;
      lock_d    = lock_q;
      lock_id_d = lock_id_q;
      err_d     = err_q | d_hit_zero;
      if (a_fire) begin
         last_d = win;
         lock_d = 1'b0;
      end else if (auto_out_a_valid) begin
         lock_d    = 1'b1;
         lock_id_d = win;
      end
      cnt0_d = next_cnt(cnt0_q, a_fire & ~win, d_fire & ~d_id);
      cnt1_d = next_cnt(cnt1_q, a_fire &  win, d_fire &  d_id);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         last_q    <= 1'b1;
         lock_q    <= 1'b0;
         lock_id_q <= 1'b0;
         cnt0_q    <= 4'd0;
         cnt1_q    <= 4'd0;
         err_q     <= 1'b0;
      end else begin
         last_q    <= last_d;
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
         cnt0_q    <= cnt0_d;
         cnt1_q    <= cnt1_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: doc/tl_a_client_arbiter.md
# tl_a_client_arbiter

Two-client TileLink-UL arbiter that shares one buffered TileLink link, a TLBuffer instance with a 10-bit source field, between two 9-bit-source clients. It sits directly upstream of that buffer's `auto_in` node. The A channel is arbitrated round-robin with grant locking across back-pressure. Client identity is encoded in source bit 9, and D responses are routed back by that bit. Per-client outstanding-request counters enforce a credit limit and detect stray responses.

## Interface
Parameters:
- MAX_OUTSTANDING, default 8: maximum in-flight A requests per client, legal range 1..15.

Ports (N ∈ {0,1}):
- clock  in  1  sole clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- auto_inN_a_ready  out  1  client N A accepted
- auto_inN_a_valid  in  1  client N A request
- auto_inN_a_bits_{opcode,param,size,source,address,mask,data}  in  3,3,2,9,33,8,64  client N A payload
- auto_inN_d_ready  in  1  client N accepts D
- auto_inN_d_valid  out  1  D response for client N
- auto_inN_d_bits_{opcode,param,size,source,sink,denied,data,corrupt}  out  3,2,2,9,1,1,64,1  D payload, source = out source[8:0]
- auto_out_a_ready  in  1  buffer accepts A
- auto_out_a_valid  out  1  arbitrated A request
- auto_out_a_bits_{opcode,param,size,source,address,mask,data}  out  3,3,2,10,33,8,64  source = {grant, inN source}
- auto_out_d_ready  out  1  D accepted by selected client
- auto_out_d_valid  in  1  D response from buffer
- auto_out_d_bits_{opcode,param,size,source,sink,denied,data,corrupt}  in  3,2,2,10,1,1,64,1
- stray_d_err  out  1  sticky: D arrived for a client with zero outstanding requests

## Operation
- State: `last` (1 b, most recent winner), `lock` (1 b), `lock_id` (1 b), `cnt0`/`cnt1` (4 b each), `err` (1 b).
- Eligibility: client N is eligible when `auto_inN_a_valid` is high and `cntN` < MAX_OUTSTANDING.
- Arbitration when `lock`=0:
  - Exactly one client eligible: that client wins.
  - Both eligible: the client other than `last` wins.
  - Neither eligible: `auto_out_a_valid`=0.
- Arbitration when `lock`=1: winner is `lock_id`, regardless of the other client.
- A outputs:
  - `auto_out_a_valid` = winner eligible.
  - `auto_out_a_bits_*` = winner payload; `source` = {winner, source[8:0]}.
  - `auto_inN_a_ready` = `auto_out_a_ready` & (winner==N) & eligible.
  - The loser's ready is 0.
- A fire = out valid & out ready. On fire: `last`←winner, `lock`←0, `cnt[winner]`+1.
- Stall: out valid & !out ready sets `lock`←1 and `lock_id`←winner. This keeps the offered beat stable; the grant never switches mid-handshake.
- D routing: `id` = `auto_out_d_bits_source[9]`.
  - `auto_in{id}_d_valid` = `auto_out_d_valid`; the other client's d_valid = 0.
  - `auto_out_d_ready` = `auto_in{id}_d_ready`.
  - Payload is fanned out to both clients; source is bits [8:0].
- D fire decrements `cnt[id]`.
- Same client, A fire and D fire in the same cycle: count unchanged.
- D fire with `cnt[id]`=0: count stays 0 and `err`←1.
- `err` clears only on reset.

## Timing
- A and D paths are combinational: zero-cycle latency from input to output.
- Only arbitration and credit state is registered.
- Reset asserted (reset=0), asynchronous:
  - `last`=1, so client 0 wins the first contention.
  - `lock`=0, `lock_id`=0, counts=0, `err`=0.
  - All `*_valid`, `*_ready` and `stray_d_err` outputs are forced to 0 while reset is low.
- Deassertion takes effect at the next rising edge.
- Reset mid-handshake drops the locked beat and all credit counts.
- Credit limit: a client at MAX_OUTSTANDING is masked from the next cycle on.
  - A same-cycle D fire for that client does not unmask it until the following cycle, because eligibility uses registered counts.
- Counts never wrap: increment is blocked at MAX_OUTSTANDING, and decrement at 0 flags `err`.

## Test plan
- Both clients valid every cycle, out_a_ready=1 for 6 cycles after reset → grants 0,1,0,1,0,1; out sources carry bit9 = 0,1,0,1,0,1.
- Client 0 valid, out_a_ready=0 for 3 cycles; client 1 raises valid in cycle 2 → out stays client 0 with identical payload until ready; client 1 is granted on the next cycle.
- MAX_OUTSTANDING=2: client 1 issues 2 A fires with no D → `auto_in1_a_ready`=0 while client 0 continues. D with source 0x2xx fires → client 1 is granted again one cycle later.
- D with source 0x305, in1_d_ready=0 for 2 cycles → `auto_out_d_ready`=0 for those cycles; `auto_in1_d_bits_source`=0x105; `auto_in0_d_valid` stays 0.
- Client 0 at cnt=1: A fire and D fire for client 0 in the same cycle → `cnt0` remains 1.
- D with source 0x000 while cnt0=0 → `stray_d_err`=1 from the next cycle and it stays set. Assert reset=0 mid-lock → all valid/ready outputs, lock and counts go to 0 immediately.
